// File: rtl/nn_frame_sequencer_if.sv
// Bus bundle for nn_frame_sequencer.
//   fb_*   : synchronous-RAM read port; read data is valid 1 cycle after fb_rd_en
//   axis_* : pixel stream to the network (valid/ready)
//   m_*    : AXI-Lite read-address and read-data channels used to fetch the result
// master = sequencer side, slave = frame buffer / network side.
interface nn_frame_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int AXI_W  = 32
);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [DATA_W-1:0] fb_rd_data;

    logic [DATA_W-1:0] axis_data;
    logic              axis_valid;
    logic              axis_ready;

    logic [31:0]       m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [AXI_W-1:0]  m_rdata;
    logic              m_rvalid;
    logic              m_rready;

    modport master (
        output fb_rd_en, fb_rd_addr, input fb_rd_data,
        output axis_data, axis_valid, input axis_ready,
        output m_araddr, m_arvalid, input m_arready,
        input m_rdata, m_rvalid, output m_rready
    );

    modport slave (
        input fb_rd_en, fb_rd_addr, output fb_rd_data,
        input axis_data, axis_valid, output axis_ready,
        input m_araddr, m_arvalid, output m_arready,
        output m_rdata, m_rvalid, input m_rready
    );
endinterface

// File: rtl/nn_frame_sequencer.sv
// nn_frame_sequencer: on a start pulse, streams NUM_PIX pixels from a frame
// buffer to the network, waits for the network's done level (intr) with a
// timeout, reads the classification over AXI-Lite and reports it.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : 1-cycle pulse, frame captured (ignored while busy)
//   intr              : network-done level
//   bus               : frame-buffer read port, pixel stream, AXI-Lite read master
//   result            : classification (8'hFF on timeout), held until next capture
//   result_valid      : 1-cycle pulse when result is updated
//   busy              : a frame is in flight
//   timeout_err       : sticky, cleared by reset or an accepted start
module nn_frame_sequencer #(
    parameter int DATA_W      = 8,
    parameter int NUM_PIX     = 784,
    parameter int ADDR_W      = 10,
    parameter int AXI_W       = 32,
    parameter int RESULT_ADDR = 8,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 intr,
    nn_frame_sequencer_if.master bus,
    output logic [7:0]           result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);
    // Read counter value once every pixel has been requested (NUM_PIX < 2**ADDR_W).
    localparam logic [ADDR_W-1:0] END_PIX  = ADDR_W'(NUM_PIX);

    typedef enum logic [2:0] {IDLE, STREAM, WAIT_INTR, AR, R, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;   // next pixel to request
    logic [ADDR_W-1:0]        tx_cnt_q, tx_cnt_d;     // pixels handed to the network
    logic                     rd_pend_q, rd_pend_d;   // RAM data arrives this cycle
    logic [1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [1:0][DATA_W-1:0]   buf_q, buf_d;           // [0] is the head
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [31:0]              araddr_q, araddr_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic [7:0]               result_q, result_d;
    logic                     result_valid_q, result_valid_d;
    logic                     busy_q, busy_d;
    logic                     timeout_err_q, timeout_err_d;

    logic                     axis_valid;
    logic                     pop;
    logic [2:0]               occ_next;
    logic                     rd_en;
    logic [TO_W-1:0]          to_inc;
    logic                     unused_rdata;

    assign axis_valid = (fifo_cnt_q != 2'd0);
    assign pop        = axis_valid & bus.axis_ready;
    // Buffer occupancy after this cycle's push and pop. A new read is only
    // issued if its data is guaranteed a slot next cycle, so the two entries
    // never overflow while a steady ready still gives one pixel per cycle.
    assign occ_next   = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign rd_en      = (state_q == STREAM) && (rd_addr_q != END_PIX) && (occ_next <= 3'd1);
    assign to_inc     = to_cnt_q + TO_W'(1);
    assign unused_rdata = ^bus.m_rdata[AXI_W-1:8];

    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        tx_cnt_d       = tx_cnt_q;
        rd_pend_d      = rd_en;
        fifo_cnt_d     = fifo_cnt_q;
        buf_d          = buf_q;
        to_cnt_d       = to_cnt_q;
        araddr_d       = araddr_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;

        // Skid buffer: push the returning RAM word, pop the head on handshake.
        case ({rd_pend_q, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) buf_d[0] = bus.fb_rd_data;
                else                    buf_d[1] = bus.fb_rd_data;
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                buf_d[0]   = buf_q[1];
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    buf_d[0] = bus.fb_rd_data;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = bus.fb_rd_data;
                end
            end
            default: ;
        endcase

        if (rd_en) rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (pop)   tx_cnt_d  = tx_cnt_q + ADDR_W'(1);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d       = STREAM;
                    rd_addr_d     = '0;
                    tx_cnt_d      = '0;
                    rd_pend_d     = 1'b0;
                    fifo_cnt_d    = 2'd0;
                    timeout_err_d = 1'b0;
                end
            end
            STREAM: begin
                if (pop && tx_cnt_q == LAST_PIX) begin
                    state_d  = WAIT_INTR;
                    to_cnt_d = '0;
                end
            end
            WAIT_INTR: begin
                to_cnt_d = to_inc;
                // intr takes priority over a timeout landing in the same cycle
                if (intr) begin
                    state_d = AR;
                end else if (to_inc == TO_W'(TIMEOUT)) begin
                    state_d        = IDLE;
                    timeout_err_d  = 1'b1;
                    result_d       = 8'hFF;
                    result_valid_d = 1'b1;
                end
            end
            AR: if (bus.m_arready) state_d = R;
            R: begin
                if (bus.m_rvalid) begin
                    result_d = bus.m_rdata[7:0];
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        arvalid_d = (state_d == AR);
        rready_d  = (state_d == R);
        busy_d    = (state_d == STREAM) || (state_d == WAIT_INTR) || (state_d == AR) || (state_d == R);
        if (state_d == DONE) result_valid_d = 1'b1;
        if (state_d == AR)   araddr_d = 32'(RESULT_ADDR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rd_addr_q      <= '0;
            tx_cnt_q       <= '0;
            rd_pend_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            buf_q          <= '0;
            to_cnt_q       <= '0;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            result_q       <= 8'h00;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            tx_cnt_q       <= tx_cnt_d;
            rd_pend_q      <= rd_pend_d;
            fifo_cnt_q     <= fifo_cnt_d;
            buf_q          <= buf_d;
            to_cnt_q       <= to_cnt_d;
            araddr_q       <= araddr_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Address is parked at 0 when no read is issued so it never leaves 0..NUM_PIX-1.
    assign bus.fb_rd_en   = rd_en;
    assign bus.fb_rd_addr = rd_en ? rd_addr_q : '0;
    assign bus.axis_data  = buf_q[0];
    assign bus.axis_valid = axis_valid;
    assign bus.m_araddr   = araddr_q;
    assign bus.m_arvalid  = arvalid_q;
    assign bus.m_rready   = rready_q;
    assign result         = result_q;
    assign result_valid   = result_valid_q;
    assign busy           = busy_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_nn_frame_sequencer.sv
module tb_nn_frame_sequencer;
    localparam int NPIX = 784;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       reset, start, intr;
    logic [7:0] result;
    logic       result_valid, busy, timeout_err;

    nn_frame_sequencer_if #(.DATA_W(8), .ADDR_W(10), .AXI_W(32)) bus_if ();

    nn_frame_sequencer #(
        .DATA_W(8), .NUM_PIX(NPIX), .ADDR_W(10), .AXI_W(32), .RESULT_ADDR(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .intr(intr), .bus(bus_if),
        .result(result), .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Frame buffer: synchronous read, 1-cycle latency.
    logic [7:0] mem [0:NPIX-1];
    always @(posedge clk)
        if (bus_if.fb_rd_en && bus_if.fb_rd_addr < 10'(NPIX))
            bus_if.fb_rd_data <= mem[bus_if.fb_rd_addr];

    // Network ready: 0 = always ready, 1 = random 50%.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        bus_if.axis_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Reference model: beat k of a frame must carry mem[k]; stalled beats must
    // not change; no read address past the last pixel.
    int cyc = 0;
    int beats = 0, data_err = 0, stall_err = 0, addr_err = 0, rv_cnt = 0;
    int first_cyc = 0, last_cyc = 0;
    int beat_base = 0, de0 = 0, se0 = 0, ae0 = 0, rv0 = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus_if.fb_rd_en && bus_if.fb_rd_addr > 10'd783) addr_err <= addr_err + 1;
            if (prev_stall && (bus_if.axis_valid !== 1'b1 || bus_if.axis_data !== prev_data))
                stall_err <= stall_err + 1;
            if (bus_if.axis_valid && bus_if.axis_ready) begin
                if ((beats - beat_base) >= NPIX || bus_if.axis_data !== mem[beats - beat_base])
                    data_err <= data_err + 1;
                if (beats == beat_base) first_cyc <= cyc;
                last_cyc <= cyc;
                beats    <= beats + 1;
            end
            prev_stall <= bus_if.axis_valid && !bus_if.axis_ready;
            prev_data  <= bus_if.axis_data;
            if (result_valid) rv_cnt <= rv_cnt + 1;
        end
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        beat_base = beats; de0 = data_err; se0 = stall_err; ae0 = addr_err; rv0 = rv_cnt;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while ((beats - beat_base) < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'((beats - beat_base) >= n), 32'd1);
    endtask

    task automatic axi_read(input int ar_stall, input int r_delay, input logic [7:0] rd, input string tag);
        int k = 0;
        int bad = 0;
        logic [7:0] old;
        while (bus_if.m_arvalid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check({tag, " arvalid"}, 32'(bus_if.m_arvalid), 32'd1);
        intr = 1'b0;
        old  = result;
        for (int i = 0; i < ar_stall; i++) begin
            if (bus_if.m_arvalid !== 1'b1 || bus_if.m_araddr !== 32'd8) bad++;
            tick();
        end
        check({tag, " ar held"}, 32'(bad), 32'd0);
        check({tag, " araddr"}, bus_if.m_araddr, 32'd8);
        bus_if.m_arready = 1'b1;
        tick();
        bus_if.m_arready = 1'b0;
        check({tag, " arvalid drop"}, 32'(bus_if.m_arvalid), 32'd0);
        check({tag, " rready"}, 32'(bus_if.m_rready), 32'd1);
        bad = 0;
        for (int i = 0; i < r_delay; i++) begin
            if (result !== old || result_valid !== 1'b0 || bus_if.m_rready !== 1'b1) bad++;
            tick();
        end
        check({tag, " r wait"}, 32'(bad), 32'd0);
        bus_if.m_rvalid = 1'b1;
        bus_if.m_rdata  = {24'($urandom), rd};
        tick();
        bus_if.m_rvalid = 1'b0;
        check({tag, " rv pulse"}, 32'(result_valid), 32'd1);
        check({tag, " result"}, 32'(result), 32'(rd));
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " rready low"}, 32'(bus_if.m_rready), 32'd0);
        tick();
        check({tag, " rv end"}, 32'(result_valid), 32'd0);
        check({tag, " result hold"}, 32'(result), 32'(rd));
    endtask

    initial begin
        int bad;
        logic [7:0] rd;
        reset = 1'b1; start = 1'b0; intr = 1'b0;
        bus_if.m_arready = 1'b0; bus_if.m_rvalid = 1'b0; bus_if.m_rdata = '0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        repeat (3) tick();

        // Reset state
        check("rst axis_valid", 32'(bus_if.axis_valid), 32'd0);
        check("rst fb_rd_en", 32'(bus_if.fb_rd_en), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst result_valid", 32'(result_valid), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        check("rst arvalid", 32'(bus_if.m_arvalid), 32'd0);
        check("rst araddr", bus_if.m_araddr, 32'd0);
        check("rst rready", 32'(bus_if.m_rready), 32'd0);

        // Full speed: start in the same cycle reset is released
        reset = 1'b0;
        clr();
        pulse_start();
        check("fs busy", 32'(busy), 32'd1);
        tick(); tick();
        check("fs first valid", 32'(bus_if.axis_valid), 32'd1);
        check("fs first data", 32'(bus_if.axis_data), 32'd0);
        wait_beats(NPIX, 3000, "fs beats");
        check("fs data", 32'(data_err - de0), 32'd0);
        check("fs rate", 32'(last_cyc - first_cyc), 32'(NPIX - 1));
        check("fs valid after last", 32'(bus_if.axis_valid), 32'd0);
        check("fs busy wait", 32'(busy), 32'd1);
        repeat (10) tick();
        intr = 1'b1;
        axi_read(0, 2, 8'd7, "fs");
        check("fs rv count", 32'(rv_cnt - rv0), 32'd1);

        // Backpressure, random frame; start+intr together, intr held high
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        clr();
        rdy_mode = 1;
        intr = 1'b1;
        pulse_start();
        check("bp start wins", 32'(busy), 32'd1);
        check("bp no ar", 32'(bus_if.m_arvalid), 32'd0);
        wait_beats(NPIX, 6000, "bp beats");
        check("bp data", 32'(data_err - de0), 32'd0);
        check("bp stall", 32'(stall_err - se0), 32'd0);
        check("bp addr", 32'(addr_err - ae0), 32'd0);
        tick();
        check("bp early intr", 32'(bus_if.m_arvalid), 32'd1);
        rd = 8'($urandom);
        axi_read(20, 3, rd, "bp");
        check("bp rv count", 32'(rv_cnt - rv0), 32'd1);

        // Timeout
        clr();
        rdy_mode = 0;
        pulse_start();
        wait_beats(NPIX, 3000, "to beats");
        check("to valid after last", 32'(bus_if.axis_valid), 32'd0);
        bad = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (timeout_err !== 1'b0 || result_valid !== 1'b0) bad++;
        end
        check("to early", 32'(bad), 32'd0);
        tick();
        check("to err", 32'(timeout_err), 32'd1);
        check("to result", 32'(result), 32'hFF);
        check("to rv", 32'(result_valid), 32'd1);
        check("to busy", 32'(busy), 32'd0);
        tick();
        check("to rv end", 32'(result_valid), 32'd0);
        repeat (5) tick();
        check("to sticky", 32'(timeout_err), 32'd1);

        // Start while busy at beat 100; the accepted start clears timeout_err
        clr();
        pulse_start();
        check("sb err clear", 32'(timeout_err), 32'd0);
        wait_beats(100, 1000, "sb beat100");
        pulse_start();
        wait_beats(NPIX, 3000, "sb beats");
        repeat (20) tick();
        check("sb total beats", 32'(beats - beat_base), 32'(NPIX));
        check("sb data", 32'(data_err - de0), 32'd0);
        check("sb still busy", 32'(busy), 32'd1);
        intr = 1'b1;
        rd = 8'($urandom);
        axi_read(0, 0, rd, "sb");
        check("sb rv count", 32'(rv_cnt - rv0), 32'd1);

        // Reset mid-stream at beat 400
        clr();
        rdy_mode = 1;
        pulse_start();
        wait_beats(400, 3000, "rs beat400");
        reset = 1'b1;
        #1;
        check("rs valid", 32'(bus_if.axis_valid), 32'd0);
        check("rs busy", 32'(busy), 32'd0);
        check("rs rd_en", 32'(bus_if.fb_rd_en), 32'd0);
        check("rs result", 32'(result), 32'd0);
        tick(); tick();
        reset = 1'b0;
        clr();
        repeat (5) tick();
        check("rs no rv", 32'(rv_cnt - rv0), 32'd0);
        check("rs idle", 32'(busy), 32'd0);
        clr();
        pulse_start();
        wait_beats(NPIX, 6000, "rs beats");
        check("rs data", 32'(data_err - de0), 32'd0);
        check("rs stall", 32'(stall_err - se0), 32'd0);
        check("rs addr", 32'(addr_err - ae0), 32'd0);
        intr = 1'b1;
        rd = 8'($urandom);
        axi_read(2, 1, rd, "rs");
        check("rs rv count", 32'(rv_cnt - rv0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule
